// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage and the data memory responder.
// The master drives requests; the slave (responder) answers and raises busy.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering one MEM-stage load/store at a time with a
// fixed number of wait states, a one-cycle response pulse and a pipeline stall.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus
);

    localparam int         ADDR_BITS = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LP_WAIT   = 4'(WAIT_CYCLES);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic f_access_error(input logic [1:0] size, input logic [1:0] off);
        logic v_err;
        case (size)
            SZ_WORD: v_err = (off != 2'b00);
            SZ_HALF: v_err = off[0];
            SZ_BYTE: v_err = 1'b0;
            default: v_err = 1'b1;
        endcase
        return v_err;
    endfunction

    function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] v_be;
        case (size)
            SZ_WORD: v_be = 4'b1111;
            SZ_HALF: v_be = off[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: v_be = 4'b0001 << off;
            default: v_be = 4'b0000;
        endcase
        return v_be;
    endfunction

    // Replicate right-justified store data onto every lane it could land in.
    function automatic logic [31:0] f_lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] v_lane;
        case (size)
            SZ_WORD: v_lane = wdata;
            SZ_HALF: v_lane = {2{wdata[15:0]}};
            SZ_BYTE: v_lane = {4{wdata[7:0]}};
            default: v_lane = 32'h0000_0000;
        endcase
        return v_lane;
    endfunction

    function automatic logic [31:0] f_load_data(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] v_sh;
        logic [31:0] v_out;
        v_sh = word >> {off, 3'b000};
        case (size)
            SZ_WORD: v_out = word;
            SZ_HALF: v_out = {(uns ? 16'h0000 : {16{v_sh[15]}}), v_sh[15:0]};
            SZ_BYTE: v_out = {(uns ? 24'h00_0000 : {24{v_sh[7]}}), v_sh[7:0]};
            default: v_out = 32'h0000_0000;
        endcase
        return v_out;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;

    logic                   r_write;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [1:0]             r_off;
    logic [31:0]            r_wdata;

    logic                   r_resp_valid;
    logic [31:0]            r_resp_rdata;
    logic                   r_resp_error;

    logic [31:0]            r_mem [DEPTH_WORDS] = '{default: 32'h0000_0000};

    logic                   w_req_ready;
    logic                   w_accept;
    logic                   w_op_write;
    logic [1:0]             w_op_size;
    logic                   w_op_unsigned;
    logic [ADDR_BITS-1:0]   w_op_idx;
    logic [1:0]             w_op_off;
    logic [31:0]            w_op_wdata;
    logic                   w_op_err;
    logic [3:0]             w_byte_en;
    logic [31:0]            w_lane;
    logic [31:0]            w_rd_word;
    logic [31:0]            w_load;
    logic                   w_commit;
    logic                   w_mem_we;
    logic                   w_unused_addr;

    assign w_req_ready   = (r_state != ST_WAIT);
    assign w_accept      = bus.req_valid && w_req_ready;
    assign w_unused_addr = ^bus.req_addr[31:ADDR_BITS+2];

    // Next state and wait counter; a zero wait count skips WAIT entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (LP_WAIT == 4'd0) begin
                        w_state_nxt = ST_RESP;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LP_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Operand source: the latched request while waiting, the live bus when
    // committing on the accept edge itself (zero wait states).
    always_comb begin
        w_op_write    = 1'b0;
        w_op_size     = 2'b00;
        w_op_unsigned = 1'b0;
        w_op_idx      = '0;
        w_op_off      = 2'b00;
        w_op_wdata    = 32'h0000_0000;
        if (r_state == ST_WAIT) begin
            w_op_write    = r_write;
            w_op_size     = r_size;
            w_op_unsigned = r_unsigned;
            w_op_idx      = r_idx;
            w_op_off      = r_off;
            w_op_wdata    = r_wdata;
        end else begin
            w_op_write    = bus.req_write;
            w_op_size     = bus.req_size;
            w_op_unsigned = bus.req_unsigned;
            w_op_idx      = bus.req_addr[ADDR_BITS+1:2];
            w_op_off      = bus.req_addr[1:0];
            w_op_wdata    = bus.req_wdata;
        end
    end

    assign w_op_err  = f_access_error(w_op_size, w_op_off);
    assign w_byte_en = f_byte_en(w_op_size, w_op_off);
    assign w_lane    = f_lane_data(w_op_size, w_op_wdata);
    assign w_rd_word = r_mem[w_op_idx];
    assign w_load    = f_load_data(w_rd_word, w_op_size, w_op_off, w_op_unsigned);
    assign w_commit  = (w_state_nxt == ST_RESP) && !Reset;
    assign w_mem_we  = w_commit && w_op_write && !w_op_err;

    // State, counter and registered response.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= w_commit;
            r_resp_error <= w_commit && w_op_err;
            r_resp_rdata <= (w_commit && !w_op_write && !w_op_err) ? w_load : 32'h0000_0000;
        end
    end

    // Request capture on accept.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_idx      <= '0;
            r_off      <= 2'b00;
            r_wdata    <= 32'h0000_0000;
        end else if (w_accept) begin
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_idx      <= bus.req_addr[ADDR_BITS+1:2];
            r_off      <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata;
        end
    end

    // Byte-lane store; contents survive Reset.
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    r_mem[w_op_idx][8*b +: 8] <= w_lane[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.busy       = w_accept || (r_state == ST_WAIT);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_error = r_resp_error;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: drivers queue expected responses, negedge monitors compare
// data, error and arrival cycle for a 2-wait-state and a 0-wait-state instance.
module tb_data_mem_responder;

    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q2[$];
    exp_t q0[$];

    data_mem_responder_if b2();
    data_mem_responder_if b0();

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .bus(b2.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .bus(b0.slave));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge Clk) begin : mon2
        exp_t e;
        if (b2.resp_valid === 1'b1) begin
            if (q2.size() == 0) begin
                chk("d2_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("d2_rdata", b2.resp_rdata, e.rdata);
                chk("d2_error", {31'd0, b2.resp_error}, {31'd0, e.err});
                chk("d2_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge Clk) begin : mon0
        exp_t e;
        if (b0.resp_valid === 1'b1) begin
            if (q0.size() == 0) begin
                chk("d0_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("d0_rdata", b0.resp_rdata, e.rdata);
                chk("d0_error", {31'd0, b0.resp_error}, {31'd0, e.err});
                chk("d0_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic req2(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr, input bit keep);
        int g;
        g = 0;
        b2.req_valid = 1'b1; b2.req_write = w; b2.req_size = sz;
        b2.req_unsigned = u; b2.req_addr = a; b2.req_wdata = wd;
        #1;
        while (b2.req_ready !== 1'b1 && g < 40) begin @(negedge Clk); #1; g++; end
        if (g >= 40) chk("d2_accept_timeout", 32'd0, 32'd1);
        chk("d2_busy_on_accept", {31'd0, b2.busy}, 32'd1);
        q2.push_back('{erd, eerr, cyc + 3});
        @(negedge Clk);
        if (!keep) b2.req_valid = 1'b0;
    endtask

    task automatic req0(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr, input bit keep,
                        output int acc);
        b0.req_valid = 1'b1; b0.req_write = w; b0.req_size = sz;
        b0.req_unsigned = u; b0.req_addr = a; b0.req_wdata = wd;
        #1;
        chk("d0_ready", {31'd0, b0.req_ready}, 32'd1);
        chk("d0_busy_on_accept", {31'd0, b0.busy}, 32'd1);
        acc = cyc + 1;
        q0.push_back('{erd, eerr, cyc + 1});
        @(negedge Clk);
        if (!keep) b0.req_valid = 1'b0;
    endtask

    // Busy-high cycles strictly between the accept edge and the response.
    task automatic busy_window2(output int nb);
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (b2.resp_valid === 1'b1) break;
            if (b2.busy === 1'b1) nb++;
            @(negedge Clk);
        end
        chk("d2_busy_low_in_resp", {31'd0, b2.busy}, 32'd0);
        @(negedge Clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (q2.size() == 0 && q0.size() == 0) break;
            @(negedge Clk);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},      {31'd0, b2.req_ready},  32'd1);
        chk({tag, "_busy"},       {31'd0, b2.busy},       32'd0);
        chk({tag, "_resp_valid"}, {31'd0, b2.resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, b2.resp_rdata,          32'd0);
        chk({tag, "_resp_error"}, {31'd0, b2.resp_error}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb;
        int acc[4];
        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_size = 2'b00;
        b2.req_unsigned = 1'b0; b2.req_addr = 32'd0; b2.req_wdata = 32'd0;
        b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_size = 2'b00;
        b0.req_unsigned = 1'b0; b0.req_addr = 32'd0; b0.req_wdata = 32'd0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_d0_resp_valid", {31'd0, b0.resp_valid}, 32'd0);
        chk("rst_d0_ready", {31'd0, b0.req_ready}, 32'd1);
        Reset = 1'b0;
        @(negedge Clk);

        // Store then load a word, measuring the stall window each time
        req2(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        busy_window2(nb);
        chk("d2_busy_cycles_store", 32'(nb), 32'd2);
        req2(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        busy_window2(nb);
        chk("d2_busy_cycles_load", 32'(nb), 32'd2);

        // Byte store and extension
        req2(1'b1, SZ_B, 1'b0, 32'h13, 32'h80, 32'h0, 1'b0, 1'b0);
        req2(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
        req2(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 1'b0);
        req2(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0);
        req2(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 1'b0);
        req2(1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 1'b0);
        req2(1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 1'b0);

        // Errors: misaligned half/word, reserved size, misaligned store
        req2(1'b0, SZ_H, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1'b0);
        req2(1'b0, SZ_W, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1'b0);
        req2(1'b0, SZ_R, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        req2(1'b1, SZ_H, 1'b0, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1'b0);
        req2(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0);

        // Back-to-back read-after-write
        req2(1'b1, SZ_W, 1'b0, 32'h14, 32'h11223344, 32'h0, 1'b0, 1'b1);
        req2(1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 32'h11223344, 1'b0, 1'b0);
        drain();

        // Reset drops an in-flight store
        req2(1'b1, SZ_W, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        drain();
        b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_size = SZ_W;
        b2.req_unsigned = 1'b0; b2.req_addr = 32'h20; b2.req_wdata = 32'h12345678;
        #1;
        chk("d2_ready_before_drop", {31'd0, b2.req_ready}, 32'd1);
        @(negedge Clk);
        b2.req_valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        chk_reset_outputs("midrst");
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        req2(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

        // Address wrap
        req2(1'b1, SZ_W, 1'b0, 32'h1000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        req2(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        drain();

        // Zero wait states, valid held for four requests
        req0(1'b1, SZ_W, 1'b0, 32'h40, 32'h01020304, 32'h0, 1'b0, 1'b1, acc[0]);
        req0(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h01020304, 1'b0, 1'b1, acc[1]);
        req0(1'b1, SZ_B, 1'b0, 32'h41, 32'hFF, 32'h0, 1'b0, 1'b1, acc[2]);
        req0(1'b0, SZ_H, 1'b0, 32'h40, 32'h0, 32'hFFFFFF04, 1'b0, 1'b0, acc[3]);
        for (int i = 1; i < 4; i++) chk("d0_consecutive_accept", 32'(acc[i] - acc[i-1]), 32'd1);
        drain();
        repeat (2) @(negedge Clk);

        chk("q2_empty", 32'(q2.size()), 32'd0);
        chk("q0_empty", 32'(q0.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the datapath's MEM-stage load/store requests. Accepts one request at a time over a valid/ready handshake and holds an internal word-organised memory. Inserts a programmable number of wait states and returns a single-cycle response pulse carrying aligned, extended load data or a store acknowledge. Drives a `busy` stall that the hazard logic uses to freeze the pipeline while an access is outstanding.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.
- `WAIT_CYCLES`, default 2: wait states between accept and response; legal range 0..15.

- `Clk` input 1: clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: a request is presented.
- `req_ready` output 1: the responder can accept a request this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 = word, 01 = half, 10 = byte, 11 = reserved (error).
- `req_unsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output 32: load result; 0 for stores and errors.
- `resp_error` output 1: qualified by `resp_valid`; misaligned access or reserved size.
- `busy` output 1: stall request to the hazard unit.

## Operation
- States: IDLE, WAIT, RESP.
- `req_ready` = 1 in IDLE and RESP, 0 in WAIT.
- An accept occurs on a rising edge where `req_valid && req_ready`.
- On accept, the block latches write, size, unsigned, addr and wdata.
- Accept with `WAIT_CYCLES`=0 goes directly to RESP.
- Accept with `WAIT_CYCLES`>0 goes to WAIT with counter = `WAIT_CYCLES`.
- In WAIT, the counter decrements each edge. The edge at which the counter equals 1 moves the state to RESP.
- RESP lasts exactly one cycle. RESP goes to IDLE, or to WAIT/RESP if a new request is accepted in that cycle (back-to-back).
- Commit happens on the edge entering RESP:
  - a store updates the selected byte lanes;
  - a load registers the extended data into `resp_rdata`;
  - `resp_error` is registered.
- Word index = `req_addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4*`DEPTH_WORDS` bytes.
- Byte lanes are little-endian; offset `addr[1:0]` selects bits [8*off+7 : 8*off].
  - Half access uses lanes {addr[1],0}/{addr[1],1}.
- Alignment rules:
  - a word needs `addr[1:0]`=00;
  - a half needs `addr[0]`=0;
  - a byte is always aligned.
- A misaligned access or size 11 produces the same latency with `resp_error`=1, no memory write, and `resp_rdata`=0.
- Loads return data shifted to bit 0, then sign- or zero-extended to 32 bits. Word loads are unaffected by `req_unsigned`.
- A store response has `resp_valid`=1, `resp_rdata`=0, and `resp_error` per the alignment rules.
- `busy` = (`req_valid && req_ready`) || state==WAIT, and is combinational.
  - It is high from the accept cycle through the cycle before `resp_valid`.
  - It is low in the RESP cycle unless a new accept occurs.
- Request inputs are ignored while `req_ready`=0. The requester holds them until accepted.
- Memory contents are not cleared by `Reset`; they initialise to 0 at time zero.

## Timing
- Reset values: state IDLE, counter 0, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `req_ready`=1, `busy`=0 (given `req_valid`=0).
- Latency: for an accept at edge k, `resp_valid` is high in the cycle after edge k+`WAIT_CYCLES`.
  - `WAIT_CYCLES`=0 gives one cycle; `WAIT_CYCLES`=2 gives three cycles.
- Throughput: one request per `WAIT_CYCLES`+1 cycles with back-to-back accepts in RESP.
- Read-after-write to the same address on back-to-back requests returns the new data, because the store commits before the load is accepted.
- Reset mid-operation:
  - an in-flight request is dropped, with no write committed and no response;
  - `Reset` overrides an accept on the same edge.
- The counter is 4 bits and never underflows; WAIT is exited only through the count==1 transition.

## Test plan
- `WAIT_CYCLES`=2:
  - store word 0xDEADBEEF at addr 0x10, then load word at 0x10;
  - required: each response arrives 3 cycles after accept, the load returns 0xDEADBEEF, and `busy` is high for 2 cycles per access.
- Store byte 0x80 at 0x13, then load byte at 0x13 signed and unsigned:
  - required: 0xFFFFFF80 and 0x00000080;
  - required: a word load at 0x10 returns 0x80ADBEEF.
- Load half at 0x11 and load word at 0x12:
  - required: `resp_error`=1 and `resp_rdata`=0;
  - required: a subsequent word load at 0x10 shows memory unchanged.
- `WAIT_CYCLES`=0, `req_valid` held high for 4 consecutive requests:
  - required: 4 accepts on consecutive edges;
  - required: `resp_valid` high for 4 consecutive cycles;
  - required: `busy` high on each accept cycle.
- Assert `Reset` one cycle after accepting a store of 0x12345678 at 0x20 (`WAIT_CYCLES`=2):
  - required: no `resp_valid`, and a word load at 0x20 returns the prior value;
  - required: all outputs at reset values on the following cycle.
- `DEPTH_WORDS`=1024:
  - store 0xA5A5A5A5 at 0x1000, then load 0x0;
  - required: the load returns 0xA5A5A5A5 (address wrap).
